store_rmw_unit: RTL

- Sequential store unit between the datapath and a word-only data memory.
- Executes word, halfword, byte and (64-bit builds only) doubleword stores.
- Sub-word stores use read-modify-write: read the aligned word, merge the new bytes into the right lanes, write it back.
- Generalises the old combinational store-size block in data width and memory latency; adds alignment checking and a req/ready/done handshake.

---
 rtl/store_pkg.sv | 33 +++
 rtl/store_lane_merge.sv | 20 ++
 rtl/store_rmw_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared encodings and byte-lane helpers for the read-modify-write store unit.
package store_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_HALF  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone,
        StErr
    } state_e;

    // Byte-enable for up to 8 lanes; lanes above DATA_W/8 are never set for legal requests.
    function automatic logic [7:0] byte_en_mask(input logic [1:0] size,
                                                input logic [2:0] lane_addr,
                                                input logic       wide);
        logic [7:0] mask;
        unique case (size)
            SZ_BYTE:  mask = 8'h01 << (wide ? lane_addr : {1'b0, lane_addr[1:0]});
            SZ_HALF:  mask = 8'h03 << (wide ? {lane_addr[2:1], 1'b0} : {1'b0, lane_addr[1], 1'b0});
            SZ_WORD:  mask = wide ? (8'h0f << {lane_addr[2], 2'b00}) : 8'h0f;
            SZ_DWORD: mask = 8'hff;
            default:  mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the enabled byte lanes of a memory word with the pre-positioned new data.
module store_lane_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Sequential store unit: full-width stores write directly, sub-word stores read,
// merge and write back the aligned memory word.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_req,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned L     = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic        WIDE  = (DATA_W == 64);

    state_e             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]  data_q;
    logic [NB-1:0]      be_q;

    logic               illegal;
    logic               misaligned;
    logic [7:0]         be_full;
    logic [NB-1:0]      be;
    logic [DATA_W-1:0]  shifted;
    logic [ADDR_W-1:0]  aligned;
    logic [DATA_W-1:0]  merged;

    always_comb begin
        illegal    = (st_size == SZ_DWORD) && !WIDE;
        misaligned = 1'b0;
        unique case (st_size)
            SZ_HALF:  misaligned = st_addr[0];
            SZ_WORD:  misaligned = |st_addr[1:0];
            SZ_DWORD: misaligned = WIDE && (|st_addr[2:0]);
            default:  misaligned = 1'b0;
        endcase
        be_full = byte_en_mask(st_size, st_addr[2:0], WIDE);
        be      = be_full[NB-1:0];
        // Legal requests are size-aligned, so the raw lane offset positions the data.
        shifted = st_data << {st_addr[L-1:0], 3'b000};
        aligned = {st_addr[ADDR_W-1:L], {L{1'b0}}};
    end

    if (NB < 8) begin : g_unused_lanes
        logic unused_be;
        assign unused_be = ^be_full[7:NB];
    end

    store_lane_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .byte_en  (be_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            st_ready  <= 1'b1;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            data_q    <= '0;
            be_q      <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (st_req) begin
                        st_ready <= 1'b0;
                        if (illegal || misaligned) begin
                            state  <= StErr;
                            st_err <= 1'b1;
                        end else begin
                            mem_addr <= aligned;
                            data_q   <= shifted;
                            be_q     <= be;
                            if (&be) begin
                                state     <= StWrite;
                                mem_we    <= 1'b1;
                                mem_wdata <= st_data;
                            end else begin
                                state  <= StRead;
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                StRead: begin
                    state    <= StWait;
                    wait_cnt <= CNT_W'(MEM_LAT - 1);
                end
                StWait: begin
                    // Read data is valid in the last wait cycle.
                    if (wait_cnt == '0) begin
                        state     <= StWrite;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StWrite: begin
                    state   <= StDone;
                    st_done <= 1'b1;
                end
                StDone, StErr: begin
                    state    <= StIdle;
                    st_ready <= 1'b1;
                end
                default: begin
                    state    <= StIdle;
                    st_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
